// File: rtl/instr_mem_responder.sv
// Memory-side responder for the control unit's fetch handshake: one word-addressed RAM access
// per request after a programmable wait. The optional err output is enabled by `define RESP_ERR_EN.
module instr_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic              fetch,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] data,
`ifdef RESP_ERR_EN
  output logic              err,
`endif
  output logic [1:0]        state_dbg_o
);

  // Handshake: a request is Valid&fetch seen in IDLE. ready drops for WAIT_CYCLES+1 cycles,
  // then rises with the response; the initiator keeps Valid high until it sees ready return,
  // and must drop Valid for at least one sampled cycle before its next request.

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_q, data_d;
`ifdef RESP_ERR_EN
  logic                err_q, err_d;
`endif

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                req;
  logic                access;
  logic                in_range;
  logic                mem_we;
  logic [DATA_W-1:0]   rd_word;

  assign req      = Valid & fetch;
  assign access   = (state_q == ST_BUSY) && (cnt_q == '0);
  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign rd_word  = in_range ? mem[addr_q[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (!Valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    ready_d = (state_d != ST_BUSY);
    if ((state_q == ST_IDLE) && req) begin
      cnt_d   = CNT_W'(WAIT_CYCLES);
      addr_d  = addr;
      rw_d    = RW;
      wdata_d = wdata;
    end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Out-of-range accesses keep identical timing: reads return zero, writes are dropped.
    if (access) begin
      if (rw_q) begin
        data_d = rd_word;
      end else begin
        mem_we = in_range;
      end
    end
  end

`ifdef RESP_ERR_EN
  always_comb begin
    err_d = err_q;
    if (access) begin
      err_d = !in_range;
    end else if (state_d == ST_IDLE) begin
      err_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

`ifdef RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  // RAM is never cleared; a reset landing on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign ready       = ready_q;
  assign data        = data_q;
  assign state_dbg_o = state_q;

endmodule
